// File: rtl/interrupt_controller.sv
// Memory-mapped interrupt controller: synchronises raw IRQ lines, latches them as pending,
// masks them with per-source and global enables and answers single-cycle bus requests.
module interrupt_controller #(
   parameter int NUM_SOURCES = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   read_request_i,
   input  logic                   write_request_i,
   output logic                   response_o,
   input  logic [31:0]            address_i,
   input  logic [31:0]            write_data_i,
   output logic [31:0]            read_data_o,
   input  logic [NUM_SOURCES-1:0] irq_sources_i,
   output logic                   interrupt_o
);
   localparam int N = NUM_SOURCES;

   typedef enum logic [2:0] {
      REG_PENDING = 3'd0,
      REG_ENABLE  = 3'd1,
      REG_MODE    = 3'd2,
      REG_CLAIM   = 3'd3,
      REG_GLOBAL  = 3'd4
   } reg_sel_e;

   logic [N-1:0] sync_q [SYNC_STAGES];
   logic [N-1:0] s_d_q;
   logic [N-1:0] pending_q, pending_d;
   logic [N-1:0] enable_q, enable_d;
   logic [N-1:0] mode_q, mode_d;
   logic         global_q, global_d;
   logic         response_q, response_d;
   logic         interrupt_q, interrupt_d;
   logic [31:0]  read_data_q, read_data_d;

   reg_sel_e     sel;
   logic         wr_en, rd_en;
   logic [N-1:0] s_now, rise, active;
   logic [N-1:0] w1c_clr, claim_clr;
   logic         claim_valid;
   logic [4:0]   claim_idx;
   logic [31:0]  claim_word, reg_rdata;
   logic         unused_bits;

   assign sel   = reg_sel_e'(address_i[4:2]);
   assign wr_en = write_request_i;
   // A simultaneous read and write is a write: no read data, no claim side effect.
   assign rd_en = read_request_i & ~write_request_i;

   assign s_now  = sync_q[SYNC_STAGES-1];
   assign rise   = s_now & ~s_d_q;
   assign active = pending_q & enable_q;

   assign unused_bits = ^{address_i[31:5], address_i[1:0], write_data_i[31:N]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
         s_d_q <= '0;
      end else begin
         sync_q[0] <= irq_sources_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         s_d_q <= s_now;
      end
   end

   // Lowest index wins: scan from the top so the last hit is the smallest index.
   always_comb begin
      claim_valid = 1'b0;
      claim_idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (active[i]) begin
            claim_valid = 1'b1;
            claim_idx   = 5'(i);
         end
      end
   end

   assign claim_word = claim_valid ? {1'b1, 26'b0, claim_idx} : 32'h0;
   assign claim_clr  = (rd_en && sel == REG_CLAIM && claim_valid) ? (N'(1) << claim_idx) : '0;
   assign w1c_clr    = (wr_en && sel == REG_PENDING) ? write_data_i[N-1:0] : '0;

   always_comb begin
      reg_rdata = '0;
      case (sel)
         REG_PENDING: reg_rdata = 32'(pending_q);
         REG_ENABLE:  reg_rdata = 32'(enable_q);
         REG_MODE:    reg_rdata = 32'(mode_q);
         REG_CLAIM:   reg_rdata = claim_word;
         REG_GLOBAL:  reg_rdata = {31'b0, global_q};
         default:     reg_rdata = '0;
      endcase
   end

   always_comb begin
      enable_d    = enable_q;
      mode_d      = mode_q;
      global_d    = global_q;
      response_d  = read_request_i | write_request_i;
      read_data_d = rd_en ? reg_rdata : 32'h0;
      if (wr_en) begin
         case (sel)
            REG_ENABLE: enable_d = write_data_i[N-1:0];
            REG_MODE:   mode_d   = write_data_i[N-1:0];
            REG_GLOBAL: global_d = write_data_i[0];
            default:    ;
         endcase
      end
      // Edge sources: a new edge overrides any clear in the same cycle. Level sources follow s.
      pending_d   = (mode_q & ((pending_q & ~(w1c_clr | claim_clr)) | rise)) | (~mode_q & s_now);
      interrupt_d = global_q & (|active);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q   <= '0;
         enable_q    <= '0;
         mode_q      <= '0;
         global_q    <= 1'b0;
         response_q  <= 1'b0;
         read_data_q <= '0;
         interrupt_q <= 1'b0;
      end else begin
         pending_q   <= pending_d;
         enable_q    <= enable_d;
         mode_q      <= mode_d;
         global_q    <= global_d;
         response_q  <= response_d;
         read_data_q <= read_data_d;
         interrupt_q <= interrupt_d;
      end
   end

   assign response_o  = response_q;
   assign read_data_o = read_data_q;
   assign interrupt_o = interrupt_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: register table, then multi-cycle edge/level/priority/race sequences.
module tb_interrupt_controller;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        read_request_i = 1'b0;
   logic        write_request_i = 1'b0;
   logic        response_o;
   logic [31:0] address_i = '0;
   logic [31:0] write_data_i = '0;
   logic [31:0] read_data_o;
   logic [7:0]  irq_sources_i = '0;
   logic        interrupt_o;

   interrupt_controller #(.NUM_SOURCES(8), .SYNC_STAGES(2)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .read_request_i  (read_request_i),
      .write_request_i (write_request_i),
      .response_o      (response_o),
      .address_i       (address_i),
      .write_data_i    (write_data_i),
      .read_data_o     (read_data_o),
      .irq_sources_i   (irq_sources_i),
      .interrupt_o     (interrupt_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic        chk;
      string       name;
   } exp_t;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] exp;
      string       name;
   } vec_t;

   exp_t sb_q[$];
   exp_t mon_e;
   vec_t tbl[18];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endfunction

   // Called on a falling edge; the request is sampled at the next rising edge.
   task automatic bus(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] exp, input string name);
      exp_t e;
      read_request_i  = rd;
      write_request_i = wr;
      address_i       = addr;
      write_data_i    = wd;
      e.data = exp;
      e.chk  = rd;
      e.name = name;
      sb_q.push_back(e);
      @(negedge clk);
      read_request_i  = 1'b0;
      write_request_i = 1'b0;
   endtask

   always @(negedge clk) begin
      if (response_o === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("unexpected_response", {31'b0, response_o}, 32'h0);
         end else begin
            mon_e = sb_q.pop_front();
            if (mon_e.chk) check(mon_e.name, read_data_o, mon_e.data);
            else           check(mon_e.name, {31'b0, response_o}, 32'h1);
            $display("txn %-18s rdata=0x%08h", mon_e.name, read_data_o);
         end
      end else if (rst_n) begin
         check("rdata_idle", read_data_o, 32'h0);
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tbl[0]  = '{1'b0, 1'b1, 32'h04, 32'hFFFF_FFFF, 32'h0,        "wr_enable"};
      tbl[1]  = '{1'b1, 1'b0, 32'h04, 32'h0,         32'h0000_00FF, "rd_enable"};
      tbl[2]  = '{1'b0, 1'b1, 32'h08, 32'hA5A5_A5A5, 32'h0,        "wr_mode"};
      tbl[3]  = '{1'b1, 1'b0, 32'h08, 32'h0,         32'h0000_00A5, "rd_mode"};
      tbl[4]  = '{1'b0, 1'b1, 32'h10, 32'hFFFF_FFFF, 32'h0,        "wr_global"};
      tbl[5]  = '{1'b1, 1'b0, 32'h10, 32'h0,         32'h0000_0001, "rd_global"};
      tbl[6]  = '{1'b0, 1'b1, 32'h0C, 32'hFFFF_FFFF, 32'h0,        "wr_claim"};
      tbl[7]  = '{1'b1, 1'b0, 32'h0C, 32'h0,         32'h0,        "rd_claim_none"};
      tbl[8]  = '{1'b0, 1'b1, 32'h18, 32'hFFFF_FFFF, 32'h0,        "wr_unused"};
      tbl[9]  = '{1'b1, 1'b0, 32'h18, 32'h0,         32'h0,        "rd_unused18"};
      tbl[10] = '{1'b1, 1'b0, 32'h1C, 32'h0,         32'h0,        "rd_unused1c"};
      tbl[11] = '{1'b1, 1'b0, 32'h24, 32'h0,         32'h0000_00FF, "rd_alias_enable"};
      tbl[12] = '{1'b1, 1'b1, 32'h10, 32'h0,         32'h0,        "rdwr_global"};
      tbl[13] = '{1'b1, 1'b0, 32'h10, 32'h0,         32'h0,        "rd_global_clr"};
      tbl[14] = '{1'b0, 1'b1, 32'h04, 32'h0,         32'h0,        "wr_enable0"};
      tbl[15] = '{1'b0, 1'b1, 32'h08, 32'h0,         32'h0,        "wr_mode0"};
      tbl[16] = '{1'b1, 1'b0, 32'h08, 32'h0,         32'h0,        "rd_mode0"};
      tbl[17] = '{1'b1, 1'b0, 32'h00, 32'h0,         32'h0,        "rd_pending0"};

      // Reset with every source asserted
      irq_sources_i = 8'hFF;
      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("rst_response", {31'b0, response_o}, 32'h0);
         check("rst_interrupt", {31'b0, interrupt_o}, 32'h0);
         check("rst_rdata", read_data_o, 32'h0);
      end
      irq_sources_i = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      for (int a = 0; a < 8; a++) begin
         bus(1'b1, 1'b0, 32'(a * 4), 32'h0, 32'h0, $sformatf("rst_reg_%02h", a * 4));
      end
      repeat (2) @(negedge clk);

      // Reset arriving while a response is on the bus drops it
      read_request_i = 1'b1;
      address_i = 32'h04;
      @(posedge clk);
      #1;
      check("midrst_resp_before", {31'b0, response_o}, 32'h1);
      rst_n = 1'b0;
      read_request_i = 1'b0;
      #1;
      check("midrst_resp_after", {31'b0, response_o}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 18; i++) begin
         bus(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].exp, tbl[i].name);
      end
      repeat (2) @(negedge clk);

      // Edge source 0: four-cycle latency, claim clears it
      bus(1'b0, 1'b1, 32'h04, 32'h1, 32'h0, "e_wr_enable");
      bus(1'b0, 1'b1, 32'h08, 32'h1, 32'h0, "e_wr_mode");
      bus(1'b0, 1'b1, 32'h10, 32'h1, 32'h0, "e_wr_global");
      irq_sources_i[0] = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) irq_sources_i[0] = 1'b0;
         check($sformatf("edge_latency_c%0d", k), {31'b0, interrupt_o}, 32'(k == 4));
      end
      bus(1'b1, 1'b0, 32'h0C, 32'h0, 32'h8000_0000, "e_claim0");
      check("edge_irq_held", {31'b0, interrupt_o}, 32'h1);
      bus(1'b1, 1'b0, 32'h00, 32'h0, 32'h0, "e_pending_after");
      check("edge_irq_fall", {31'b0, interrupt_o}, 32'h0);

      // Level source 3
      bus(1'b0, 1'b1, 32'h08, 32'h0, 32'h0, "l_wr_mode");
      bus(1'b0, 1'b1, 32'h04, 32'h8, 32'h0, "l_wr_enable");
      irq_sources_i[3] = 1'b1;
      repeat (4) @(negedge clk);
      check("level_irq", {31'b0, interrupt_o}, 32'h1);
      bus(1'b1, 1'b0, 32'h0C, 32'h0, 32'h8000_0003, "l_claim3");
      bus(1'b0, 1'b1, 32'h00, 32'h8, 32'h0, "l_w1c");
      bus(1'b1, 1'b0, 32'h00, 32'h0, 32'h0000_0008, "l_pending_kept");
      irq_sources_i[3] = 1'b0;
      repeat (2) @(negedge clk);
      bus(1'b1, 1'b0, 32'h00, 32'h0, 32'h0000_0008, "l_pending_c2");
      bus(1'b1, 1'b0, 32'h00, 32'h0, 32'h0, "l_pending_c3");

      // Priority and masking with sources 2 and 5
      bus(1'b0, 1'b1, 32'h08, 32'h24, 32'h0, "p_wr_mode");
      bus(1'b0, 1'b1, 32'h04, 32'h24, 32'h0, "p_wr_enable");
      irq_sources_i = 8'h24;
      @(negedge clk);
      irq_sources_i = 8'h00;
      repeat (3) @(negedge clk);
      bus(1'b1, 1'b0, 32'h0C, 32'h0, 32'h8000_0002, "p_claim2");
      bus(1'b1, 1'b0, 32'h0C, 32'h0, 32'h8000_0005, "p_claim5");
      bus(1'b1, 1'b0, 32'h0C, 32'h0, 32'h0, "p_claim_none");
      bus(1'b0, 1'b1, 32'h10, 32'h0, 32'h0, "p_global_off");
      irq_sources_i = 8'h24;
      @(negedge clk);
      irq_sources_i = 8'h00;
      repeat (3) @(negedge clk);
      bus(1'b1, 1'b0, 32'h00, 32'h0, 32'h0000_0024, "p_pending24");
      for (int k = 0; k < 4; k++) begin
         check($sformatf("p_global_mask_c%0d", k), {31'b0, interrupt_o}, 32'h0);
         @(negedge clk);
      end
      bus(1'b0, 1'b1, 32'h10, 32'h1, 32'h0, "p_global_on");
      @(negedge clk);
      check("p_global_irq", {31'b0, interrupt_o}, 32'h1);

      // Set/clear race on source 1, then back-to-back reads
      bus(1'b0, 1'b1, 32'h00, 32'hFF, 32'h0, "r_w1c_all");
      bus(1'b0, 1'b1, 32'h08, 32'h2, 32'h0, "r_wr_mode");
      bus(1'b0, 1'b1, 32'h04, 32'h2, 32'h0, "r_wr_enable");
      bus(1'b1, 1'b0, 32'h00, 32'h0, 32'h0, "r_pending_clean");
      irq_sources_i[1] = 1'b1;
      @(negedge clk);
      irq_sources_i[1] = 1'b0;
      @(negedge clk);
      bus(1'b0, 1'b1, 32'h00, 32'h2, 32'h0, "r_w1c_race");
      bus(1'b1, 1'b0, 32'h00, 32'h0, 32'h0000_0002, "r_pending_kept");
      bus(1'b0, 1'b1, 32'h00, 32'h2, 32'h0, "r_w1c_plain");
      bus(1'b1, 1'b0, 32'h00, 32'h0, 32'h0, "r_pending_clr");
      bus(1'b1, 1'b0, 32'h04, 32'h0, 32'h0000_0002, "r_b2b_enable");
      bus(1'b1, 1'b0, 32'h14, 32'h0, 32'h0, "r_b2b_unused");

      repeat (4) @(negedge clk);
      check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
